cal_acc_int4_x2: RTL
====================

CAL_ACC_INT4_X2 -- requirements
Module: cal_acc_int4_x2

Interface
REQ-001 Parameter ACC_W, default 16: signed accumulator and output width; legal range 10..32.
REQ-002 Parameter CNT_W, default 8: beat-counter width; maximum group length is 2^CNT_W beats.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  ac/bc/in_last carry a beat this cycle.
REQ-006 in_ready  output  1  block accepts the beat this cycle.
REQ-007 in_last  input  1  beat closes the current dot-product group.
REQ-008 ac  input  8  signed product a*c from the paired int4 multiplier.
REQ-009 bc  input  8  signed product b*c from the paired int4 multiplier.
REQ-010 out_valid  output  1  sum_a, sum_b, ovf_a, ovf_b and beats hold a finished group.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 sum_a, sum_b  output  ACC_W each  signed group sums of ac and bc.
REQ-013 ovf_a, ovf_b  output  1 each  a saturation occurred in the group for that lane.
REQ-014 beats  output  CNT_W  beat count of the reported group minus one.

Function
REQ-015 A beat is accepted only on a cycle where in_valid=1 and in_ready=1.
REQ-016 State machine states:
  - IDLE: no open group.
  - ACC: group open.
  - HOLD: result pending with out_ready=0.
REQ-017 IDLE, accepted beat:
  - in_last=0: acc <= sext(product), counter <= 0, go to ACC.
  - in_last=1: load the outputs directly from this beat (single-beat group).
REQ-018 ACC, accepted beat: acc <= sat(acc + sext(product)), counter increments.
REQ-019 Saturation: each lane clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; a clamp sets that lane's sticky ovf bit for the group.
REQ-020 Accepted in_last beat: the final sums, ovf bits and counter are registered to the outputs, and out_valid=1 the next cycle (latency 1).
REQ-021 out_valid is held, with stable outputs, until out_ready=1.
REQ-022 out_valid=1 and out_ready=1 on the same cycle: the next state is IDLE, or ACC/output-load if a beat is accepted in that cycle.
REQ-023 in_ready = !(out_valid && !out_ready). A pending unconsumed result stalls input; no result is ever dropped.
REQ-024 Counter reaching 2^CNT_W-1 without in_last: the group is force-closed as if in_last=1 on that beat.
REQ-025 in_valid=0 while in ACC: accumulator and counter hold their values; there is no timeout.
REQ-026 in_last=1 accepted while the previous result is consumed in the same cycle: the new result replaces it without a bubble.

Reset
REQ-027 On rst=1 at a clock edge:
  - state <= IDLE.
  - out_valid, sum_a, sum_b, ovf_a, ovf_b and beats all <= 0.
  - accumulators and counter <= 0.
REQ-028 Reset mid-group discards the partial sums and produces no out_valid pulse.
REQ-029 in_ready = 1 during and immediately after reset.

Configuration
REQ-030 Macro CAL_ACC_RELU_EN defined: any negative final sum is output as 0 (ReLU) at result registration; the ovf bits are unaffected.
REQ-031 Macro CAL_ACC_RELU_EN undefined: signed sums are output unmodified.

Structure
REQ-032 Shared package cal_int4_pkg holds:
  - the state enumeration (IDLE/ACC/HOLD);
  - the product width constant PROD_W=8;
  - the saturating-add function.
REQ-033 One sub-module, cal_sat_add, instantiated twice (one per lane): ACC_W signed accumulator plus PROD_W signed addend, producing a saturated sum and a clamp flag.

Verification
REQ-034 Group ac=[6,-7,15], bc=[1,1,1], last on beat 3, out_ready=1 -> one cycle later out_valid=1 with sum_a=14, sum_b=3, beats=2, ovf=0.
REQ-035 Single beat ac=-49, bc=-49, last=1 -> sum_a=-49, sum_b=-49, beats=0. With CAL_ACC_RELU_EN defined, both sums = 0.
REQ-036 ACC_W=10, 9 beats ac=127 -> sum_a=511 and ovf_a=1; lane b with bc=0 -> sum_b=0, ovf_b=0.
REQ-037 Result pending with out_ready=0 for 5 cycles:
  - in_ready=0 throughout and outputs stable;
  - raising out_ready accepts the next beat on the same cycle.
REQ-038 rst asserted after 2 beats of a 4-beat group -> no out_valid; the following 1-beat group ac=3 reports sum_a=3.
REQ-039 CNT_W=2, 6 beats ac=1, no in_last:
  - forced close after beat 4 with sum_a=4, beats=3;
  - the remaining 2 beats open a new group.

Source files
------------

// File: rtl/cal_int4_pkg.sv
// Shared definitions for the int4 dual-lane calibration accumulator:
// FSM state encoding, product width and the saturating-add helper.
package cal_int4_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int unsigned PROD_W = 8;

    typedef struct packed {
        logic               clamp;
        logic signed [31:0] sum;
    } sat_res_t;

    // acc + addend clamped to the signed range of a 'width'-bit word
    function automatic sat_res_t sat_add(input logic signed [31:0]       acc,
                                         input logic signed [PROD_W-1:0] addend,
                                         input int unsigned              width);
        logic signed [33:0] s;
        logic signed [33:0] hi;
        logic signed [33:0] lo;
        sat_res_t           r;
        s  = 34'(acc) + 34'(addend);
        hi = (34'sd1 <<< (width - 1)) - 34'sd1;
        lo = -(34'sd1 <<< (width - 1));
        if (s > hi) begin
            r.clamp = 1'b1;
            r.sum   = 32'(hi);
        end else if (s < lo) begin
            r.clamp = 1'b1;
            r.sum   = 32'(lo);
        end else begin
            r.clamp = 1'b0;
            r.sum   = 32'(s);
        end
        return r;
    endfunction

endpackage

// File: rtl/cal_sat_add.sv
// One lane of saturating accumulation: ACC_W signed accumulator plus a
// PROD_W signed product, with a flag when the result was clamped.
module cal_sat_add
    import cal_int4_pkg::*;
#(
    parameter int ACC_W = 16
) (
    input  logic signed [ACC_W-1:0]  acc,
    input  logic signed [PROD_W-1:0] addend,
    output logic signed [ACC_W-1:0]  sum,
    output logic                     clamp
);

    sat_res_t res;

    // saturating add, narrowed back to the accumulator width
    always_comb begin
        res   = sat_add(32'(acc), addend, ACC_W);
        sum   = ACC_W'(res.sum);
        clamp = res.clamp;
    end

endmodule

// File: rtl/cal_acc_int4_x2.sv
// Dual-lane dot-product accumulator for paired int4 multiplier products.
// Groups of beats are summed with per-lane saturation; the finished group
// is held on a valid/ready output until consumed.
// Optional macro CAL_ACC_RELU_EN: negative final sums are reported as 0.
module cal_acc_int4_x2
    import cal_int4_pkg::*;
#(
    parameter int ACC_W = 16,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_last,
    input  logic signed [PROD_W-1:0] ac,
    input  logic signed [PROD_W-1:0] bc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  sum_a,
    output logic signed [ACC_W-1:0]  sum_b,
    output logic                     ovf_a,
    output logic                     ovf_b,
    output logic [CNT_W-1:0]         beats
);

    state_t                  state;
    logic signed [ACC_W-1:0] acc_a, acc_b;
    logic signed [ACC_W-1:0] base_a, base_b;
    logic signed [ACC_W-1:0] next_a, next_b;
    logic                    clamp_a, clamp_b;
    logic                    sticky_a, sticky_b;
    logic                    grp_ovf_a, grp_ovf_b;
    logic [CNT_W-1:0]        cnt, next_cnt;
    logic                    accept, close;

    function automatic logic signed [ACC_W-1:0] finalize(input logic signed [ACC_W-1:0] s);
`ifdef CAL_ACC_RELU_EN
        return s[ACC_W-1] ? '0 : s;
`else
        return s;
`endif
    endfunction

    // a beat outside an open group starts from zero, so the same adder
    // serves both the first beat and the running accumulation
    always_comb begin
        in_ready  = !(out_valid && !out_ready);
        accept    = in_valid && in_ready;
        base_a    = (state == ACC) ? acc_a : '0;
        base_b    = (state == ACC) ? acc_b : '0;
        next_cnt  = (state == ACC) ? cnt + 1'b1 : '0;
        grp_ovf_a = ((state == ACC) && sticky_a) || clamp_a;
        grp_ovf_b = ((state == ACC) && sticky_b) || clamp_b;
        close     = in_last || (next_cnt == '1);
    end

    cal_sat_add #(.ACC_W(ACC_W)) u_lane_a (
        .acc    (base_a),
        .addend (ac),
        .sum    (next_a),
        .clamp  (clamp_a)
    );

    cal_sat_add #(.ACC_W(ACC_W)) u_lane_b (
        .acc    (base_b),
        .addend (bc),
        .sum    (next_b),
        .clamp  (clamp_b)
    );

    // group FSM: accumulate, close into the output registers, hold until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            sum_a     <= '0;
            sum_b     <= '0;
            ovf_a     <= 1'b0;
            ovf_b     <= 1'b0;
            beats     <= '0;
            acc_a     <= '0;
            acc_b     <= '0;
            cnt       <= '0;
            sticky_a  <= 1'b0;
            sticky_b  <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                if (close) begin
                    out_valid <= 1'b1;
                    sum_a     <= finalize(next_a);
                    sum_b     <= finalize(next_b);
                    ovf_a     <= grp_ovf_a;
                    ovf_b     <= grp_ovf_b;
                    beats     <= next_cnt;
                    acc_a     <= '0;
                    acc_b     <= '0;
                    cnt       <= '0;
                    sticky_a  <= 1'b0;
                    sticky_b  <= 1'b0;
                    state     <= HOLD;
                end else begin
                    acc_a     <= next_a;
                    acc_b     <= next_b;
                    cnt       <= next_cnt;
                    sticky_a  <= grp_ovf_a;
                    sticky_b  <= grp_ovf_b;
                    state     <= ACC;
                end
            end else if ((state == HOLD) && out_ready) begin
                state <= IDLE;
            end
        end
    end

endmodule
